// File: rtl/lcd_pat_pkg.sv
// Shared definitions for the LCD test-pattern stream generator: mode and state
// encodings, RGB444 field widths and the colour-bar palette.
package lcd_pat_pkg;

  localparam int R_W   = 4;
  localparam int G_W   = 4;
  localparam int B_W   = 4;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } pat_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } pat_state_e;

  // Element [0] is the top band: red, green, blue, yellow, magenta, cyan, white, black.
  localparam logic [7:0][RGB_W-1:0] PALETTE = {
    12'h000, 12'hFFF, 12'h0FF, 12'hF0F,
    12'hFF0, 12'h00F, 12'h0F0, 12'hF00
  };

  function automatic logic [RGB_W-1:0] pal_lookup(input logic [2:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/lcd_pat_color.sv
// Combinational pixel colour for a given pattern mode and raster position.
// Define PATGEN_CROSSHAIR_EN to blank the crosshair row/column to black.
module lcd_pat_color
  import lcd_pat_pkg::*;
#(
  parameter int V_ACTIVE    = 160,
  parameter int BAR_ROWS    = 20,
  parameter int CHECK_SHIFT = 3,
  parameter int XH_COL      = 40,
  parameter int XH_ROW      = 80
) (
  input  logic [1:0]       mode,
  input  logic [7:0]       h,
  input  logic [7:0]       v,
  input  logic [7:0]       ofs,
  input  logic [RGB_W-1:0] bg,
  output logic [RGB_W-1:0] color
);

  localparam logic [8:0] V_SPAN = 9'(V_ACTIVE);

  // v + ofs never exceeds 2*V_ACTIVE + 95, so two conditional subtractions suffice.
  function automatic logic [7:0] wrap_row(input logic [8:0] sum);
    logic [8:0] r;
    r = sum;
    if (r >= V_SPAN) r = r - V_SPAN;
    if (r >= V_SPAN) r = r - V_SPAN;
    return r[7:0];
  endfunction

  // Band index by threshold compares instead of a divide by BAR_ROWS.
  function automatic logic [2:0] band_of(input logic [7:0] row);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, row} >= 9'(k * BAR_ROWS)) idx = 3'(k);
    end
    return idx;
  endfunction

  logic [7:0]       scroll_row;
  logic             cell_odd;
  logic [RGB_W-1:0] base;

  assign scroll_row = wrap_row({1'b0, v} + {1'b0, ofs});
  assign cell_odd   = h[CHECK_SHIFT] ^ v[CHECK_SHIFT];

  always_comb begin
    base = bg;
    case (pat_mode_e'(mode))
      MODE_SOLID:  base = bg;
      MODE_BARS:   base = pal_lookup(band_of(v));
      MODE_CHECK:  base = cell_odd ? ~bg : bg;
      MODE_SCROLL: base = pal_lookup(band_of(scroll_row));
      default:     base = bg;
    endcase
  end

`ifdef PATGEN_CROSSHAIR_EN
  assign color = ((h == 8'(XH_COL)) || (v == 8'(XH_ROW))) ? '0 : base;
`else
  logic unused_xh;
  assign unused_xh = ^{8'(XH_COL), 8'(XH_ROW)};
  assign color     = base;
`endif

endmodule

// File: rtl/lcd_pattern_stream_gen.sv
// One-frame RGB444 test-pattern source for the 80x160 SPI LCD, valid/ready
// stream with SOF/EOL/EOF markers. Optional overlay: PATGEN_CROSSHAIR_EN.
module lcd_pattern_stream_gen
  import lcd_pat_pkg::*;
#(
  parameter int H_ACTIVE    = 80,
  parameter int V_ACTIVE    = 160,
  parameter int BAR_ROWS    = 20,
  parameter int CHECK_SHIFT = 3,
  parameter int XH_COL      = 40,
  parameter int XH_ROW      = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_req,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] bg_color,
  input  logic             pix_ready,
  output logic             pix_valid,
  output logic [RGB_W-1:0] pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic [7:0]       h_cnt,
  output logic [7:0]       v_cnt,
  output logic [7:0]       frame_cnt,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [7:0] H_LAST = 8'(H_ACTIVE - 1);
  localparam logic [7:0] V_LAST = 8'(V_ACTIVE - 1);

  pat_state_e       state;
  logic [1:0]       mode_q;
  logic [RGB_W-1:0] bg_q;
  logic [7:0]       ofs_q;

  logic             start;
  logic             fire;
  logic             last_pix;
  logic             load;
  logic [1:0]       mode_sel;
  logic [RGB_W-1:0] bg_sel;
  logic [7:0]       ofs_sel;
  logic [7:0]       h_nxt;
  logic [7:0]       v_nxt;
  logic [RGB_W-1:0] color_nxt;

  assign start    = (state == ST_IDLE) && frame_req;
  assign fire     = (state == ST_STREAM) && pix_valid && pix_ready;
  assign last_pix = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign load     = start || (fire && !last_pix);

  // The first pixel is coloured from the live request inputs, later ones from the latched copy.
  always_comb begin
    mode_sel = mode_q;
    bg_sel   = bg_q;
    ofs_sel  = ofs_q;
    h_nxt    = h_cnt + 8'd1;
    v_nxt    = v_cnt;
    if (start) begin
      mode_sel = mode;
      bg_sel   = bg_color;
      ofs_sel  = frame_cnt;
      h_nxt    = '0;
      v_nxt    = '0;
    end else if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = v_cnt + 8'd1;
    end
  end

  lcd_pat_color #(
    .V_ACTIVE    (V_ACTIVE),
    .BAR_ROWS    (BAR_ROWS),
    .CHECK_SHIFT (CHECK_SHIFT),
    .XH_COL      (XH_COL),
    .XH_ROW      (XH_ROW)
  ) u_color (
    .mode  (mode_sel),
    .h     (h_nxt),
    .v     (v_nxt),
    .ofs   (ofs_sel),
    .bg    (bg_sel),
    .color (color_nxt)
  );

  // Output register stage: everything presented downstream is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      bg_q       <= '0;
      ofs_q      <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_eof    <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        pix_valid <= 1'b1;
        busy      <= 1'b1;
        pix_data  <= color_nxt;
        h_cnt     <= h_nxt;
        v_cnt     <= v_nxt;
        pix_sof   <= (h_nxt == 8'd0) && (v_nxt == 8'd0);
        pix_eol   <= (h_nxt == H_LAST);
        pix_eof   <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
      end
      case (state)
        ST_IDLE: begin
          if (frame_req) begin
            state  <= ST_STREAM;
            mode_q <= mode;
            bg_q   <= bg_color;
            ofs_q  <= frame_cnt;
          end
        end
        ST_STREAM: begin
          if (fire && last_pix) begin
            state      <= ST_DONE;
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_eof    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pattern_stream_gen.sv
// Self-checking bench for lcd_pattern_stream_gen: a spec-level colour model,
// a table of known pixel values, stalls, mid-frame noise and mid-frame reset.
`timescale 1ns/1ps
module tb_lcd_pattern_stream_gen;

  localparam int H = 80;
  localparam int V = 160;
  localparam int NPIX = H * V;
  localparam logic [11:0] PAL [0:7] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                                        12'hF0F, 12'h0FF, 12'hFFF, 12'h000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_req;
  logic [1:0]  mode;
  logic [11:0] bg_color;
  logic        pix_ready;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;
  logic [7:0]  h_cnt;
  logic [7:0]  v_cnt;
  logic [7:0]  frame_cnt;
  logic        busy;
  logic        frame_done;

  always #50 clk = ~clk;

  lcd_pattern_stream_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_req  (frame_req),
    .mode       (mode),
    .bg_color   (bg_color),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_cnt  (frame_cnt),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct {
    string       name;
    int          mode;
    logic [11:0] bg;
    int          ofs;
    int          h;
    int          v;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  bit   vec_hit[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   frame_err = 0;
  int   fc_model = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      frame_err++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input int m, input logic [11:0] bg, input int ofs,
                         input int h, input int v, input logic [11:0] exp);
    vec_t e;
    e.name = name; e.mode = m; e.bg = bg; e.ofs = ofs; e.h = h; e.v = v; e.exp = exp;
    vecs.push_back(e);
    vec_hit.push_back(1'b0);
  endtask

  function automatic logic [63:0] outs();
    return {22'd0, pix_valid, busy, frame_done, pix_sof, pix_eol, pix_eof,
            pix_data, h_cnt, v_cnt, frame_cnt};
  endfunction

  function automatic logic [63:0] pack(input bit vl, input bit bs, input bit dn, input bit sf,
                                       input bit el, input bit ef, input logic [11:0] d,
                                       input int hh, input int vv, input int fcv);
    return {22'd0, vl, bs, dn, sf, el, ef, d, 8'(hh), 8'(vv), 8'(fcv)};
  endfunction

  // Colour straight from the pattern definitions, using plain division and modulo.
  function automatic logic [11:0] model_color(input int m, input int h, input int v,
                                              input int ofs, input logic [11:0] bg);
`ifdef PATGEN_CROSSHAIR_EN
    if (h == 40 || v == 80) return 12'h000;
`endif
    case (m)
      0: return bg;
      1: return PAL[v / 20];
      2: return (((h / 8) + (v / 8)) % 2 == 0) ? bg : ~bg;
      default: return PAL[((v + ofs) % 160) / 20];
    endcase
  endfunction

  // Streams one frame; abort_at >= 0 asserts reset while that pixel index is presented.
  task automatic run_frame(input int m, input logic [11:0] bg, input int rdy_pct, input int abort_at);
    int h, v, npix, cyc, nsof, neol, neof, ofs;
    bit rdy, vld, sf, el, ef;
    h = 0; v = 0; npix = 0; cyc = 0; nsof = 0; neol = 0; neof = 0;
    ofs = fc_model;
    frame_err = 0;
    mode = 2'(m); bg_color = bg; frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    while (npix < NPIX) begin
      if (cyc > 4 * NPIX || frame_err > 20) begin
        check("frame_abandoned", 64'(npix), 64'(NPIX));
        return;
      end
      check($sformatf("pixel(%0d,%0d)", h, v), outs(),
            pack(1, 1, 0, (h == 0 && v == 0), (h == H - 1), (h == H - 1 && v == V - 1),
                 model_color(m, h, v, ofs, bg), h, v, fc_model));
      for (int i = 0; i < vecs.size(); i++) begin
        if (!vec_hit[i] && vecs[i].mode == m && vecs[i].bg == bg &&
            (vecs[i].ofs < 0 || vecs[i].ofs == ofs) && vecs[i].h == h && vecs[i].v == v) begin
          vec_hit[i] = 1'b1;
          check(vecs[i].name, 64'(pix_data), 64'(vecs[i].exp));
        end
      end
      if (npix == abort_at) begin
        rst_n = 1'b0; frame_req = 1'b0; pix_ready = 1'b0;
        step();
        check("reset_mid_frame", outs(), 64'd0);
        rst_n = 1'b1;
        fc_model = 0;
        return;
      end
      vld = pix_valid; sf = pix_sof; el = pix_eol; ef = pix_eof;
      rdy = ($urandom_range(99) < rdy_pct);
      pix_ready = rdy;
      frame_req = ($urandom_range(31) == 0);
      mode = 2'($urandom);
      bg_color = 12'($urandom);
      step();
      cyc++;
      if (rdy && vld) begin
        nsof += int'(sf); neol += int'(el); neof += int'(ef);
        npix++;
        h++;
        if (h == H) begin h = 0; v++; end
      end
    end
    fc_model = (fc_model + 1) % 256;
    frame_req = 1'b1;
    check("done_flags", 64'({pix_valid, busy, frame_done, pix_sof, pix_eol, pix_eof}), 64'(6'b001000));
    check("frame_cnt_after_done", 64'(frame_cnt), 64'(fc_model));
    step();
    frame_req = 1'b0;
    check("idle_after_done", 64'({pix_valid, busy, frame_done}), 64'd0);
    step();
    check("req_in_done_dropped", 64'({pix_valid, busy}), 64'd0);
    check("sof_count", 64'(nsof), 64'd1);
    check("eol_count", 64'(neol), 64'(V));
    check("eof_count", 64'(neof), 64'd1);
    if (rdy_pct == 100) check("full_throughput_cycles", 64'(cyc), 64'(NPIX));
  endtask

  initial begin
    rst_n = 1'b0; frame_req = 1'b0; mode = 2'd0; bg_color = 12'h000; pix_ready = 1'b0;

    add_vec("m0_origin",      0, 12'h0F0, -1, 0,  0,   12'h0F0);
    add_vec("m0_last",        0, 12'h0F0, -1, 79, 159, 12'h0F0);
    add_vec("m1_row0",        1, 12'h5A5, -1, 0,  0,   12'hF00);
    add_vec("m1_row19",       1, 12'h5A5, -1, 7,  19,  12'hF00);
    add_vec("m1_row20",       1, 12'h5A5, -1, 0,  20,  12'h0F0);
    add_vec("m1_row60",       1, 12'h5A5, -1, 10, 60,  12'hFF0);
    add_vec("m1_row159",      1, 12'h5A5, -1, 79, 159, 12'h000);
    add_vec("m2_0_0",         2, 12'h123, -1, 0,  0,   12'h123);
    add_vec("m2_8_0",         2, 12'h123, -1, 8,  0,   12'hEDC);
    add_vec("m2_8_8",         2, 12'h123, -1, 8,  8,   12'h123);
    add_vec("m3_ofs3_row159", 3, 12'h000, 3,  0,  159, 12'hF00);
    add_vec("m3_ofs4_row17",  3, 12'h000, 4,  0,  17,  12'h0F0);
    add_vec("m3_ofs5_row0",   3, 12'h000, 5,  0,  0,   12'hF00);
    add_vec("m3_ofs5_row15",  3, 12'h000, 5,  0,  15,  12'h0F0);
`ifdef PATGEN_CROSSHAIR_EN
    add_vec("xh_col40",       0, 12'h0F0, -1, 40, 10,  12'h000);
    add_vec("xh_row80",       0, 12'h0F0, -1, 3,  80,  12'h000);
`endif

    repeat (3) step();
    check("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    step();
    check("idle_without_req", outs(), 64'd0);

    pix_ready = 1'b1;
    run_frame(0, 12'h0F0, 100, -1);
    run_frame(1, 12'h5A5, 80, -1);
    run_frame(2, 12'h123, 100, -1);
    run_frame(3, 12'h000, 100, -1);
    run_frame(3, 12'h000, 100, -1);
    run_frame(3, 12'h000, 100, 5000);
    step();
    check("idle_after_reset", outs(), 64'd0);
    run_frame(1, 12'h5A5, 100, 200);

    for (int i = 0; i < vecs.size(); i++)
      check({"vec_reached_", vecs[i].name}, 64'(vec_hit[i]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
